// File: rtl/axis_lrelu_config_sequencer_pkg.sv
// Shared constants for the LReLU input sequencer: FSM encoding, default
// burst-size parameters and sideband bit placement.
package axis_lrelu_config_sequencer_pkg;

    localparam int DEF_BITS_KERNEL_H = 2;
    localparam int DEF_CFG_BEATS_K1  = 4;
    localparam int DEF_CFG_BEATS_K3  = 8;

    localparam logic [1:0] CFG_FIRST = 2'd0;
    localparam logic [1:0] CFG_REST  = 2'd1;
    localparam logic [1:0] DATA      = 2'd2;

    typedef enum logic [1:0] {
        ST_CFG_FIRST = CFG_FIRST,
        ST_CFG_REST  = CFG_REST,
        ST_DATA      = DATA
    } seq_state_e;

    // is_config sits directly above the source tuser bits on the merged stream
    function automatic int is_config_bit(input int tuser_width);
        return tuser_width;
    endfunction

    function automatic int cfg_cnt_width(input int beats_a, input int beats_b);
        int max_beats;
        max_beats = (beats_a > beats_b) ? beats_a : beats_b;
        return (max_beats > 2) ? $clog2(max_beats) : 1;
    endfunction

endpackage

// File: rtl/axis_lrelu_config_sequencer_skid.sv
// Two-entry AXI-Stream slice with a registered upstream ready; output is
// always driven from a register and held stable while stalled.
module axis_skid_buffer #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             s_valid_i,
    output logic             s_ready_o,
    input  logic [WIDTH-1:0] s_data_i,
    output logic             m_valid_o,
    input  logic             m_ready_i,
    output logic [WIDTH-1:0] m_data_o
);

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             skid_valid_q, skid_valid_d;
    logic [WIDTH-1:0] skid_data_q, skid_data_d;
    logic             ready_q, ready_d;
    logic             in_hs;
    logic             out_free;

    assign in_hs    = s_valid_i & ready_q;
    assign out_free = ~out_valid_q | m_ready_i;

    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        if (out_free) begin
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_data_d   = skid_data_q;
                skid_valid_d = in_hs;
                if (in_hs) begin
                    skid_data_d = s_data_i;
                end
            end else begin
                out_valid_d = in_hs;
                if (in_hs) begin
                    out_data_d = s_data_i;
                end
            end
        end else if (in_hs) begin
            // Output stalled: park the beat accepted on the strength of last cycle's ready
            skid_valid_d = 1'b1;
            skid_data_d  = s_data_i;
        end
        ready_d = ~skid_valid_d;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            ready_q      <= 1'b0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            ready_q      <= ready_d;
        end
    end

    assign s_ready_o = ready_q;
    assign m_valid_o = out_valid_q;
    assign m_data_o  = out_data_q;

endmodule

// File: rtl/axis_lrelu_config_sequencer.sv
// Merges the config and data streams into the interleaved stream the LReLU
// engine expects: a kh_1-sized config burst, then data up to tlast.
module axis_lrelu_config_sequencer
    import axis_lrelu_config_sequencer_pkg::*;
#(
    parameter int DATA_WIDTH    = 512,
    parameter int TUSER_WIDTH   = 8,
    parameter int BITS_KERNEL_H = DEF_BITS_KERNEL_H,
    parameter int CFG_BEATS_K1  = DEF_CFG_BEATS_K1,
    parameter int CFG_BEATS_K3  = DEF_CFG_BEATS_K3,
    parameter int ITER_WIDTH    = 16
) (
    input  logic                   aclk,
    input  logic                   aresetn,
    input  logic                   s_cfg_tvalid,
    output logic                   s_cfg_tready,
    input  logic [DATA_WIDTH-1:0]  s_cfg_tdata,
    input  logic [TUSER_WIDTH-1:0] s_cfg_tuser,
    input  logic                   s_dat_tvalid,
    output logic                   s_dat_tready,
    input  logic [DATA_WIDTH-1:0]  s_dat_tdata,
    input  logic [TUSER_WIDTH-1:0] s_dat_tuser,
    input  logic                   s_dat_tlast,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic [DATA_WIDTH-1:0]  m_axis_tdata,
    output logic [TUSER_WIDTH:0]   m_axis_tuser,
    output logic                   m_axis_tlast,
    output logic [ITER_WIDTH-1:0]  iter_count,
    output logic [1:0]             debug_state
);

    localparam int MUSER_W    = TUSER_WIDTH + 1;
    localparam int IS_CFG_BIT = is_config_bit(TUSER_WIDTH);
    localparam int SKID_W     = DATA_WIDTH + TUSER_WIDTH + 2;
    localparam int CNT_W      = cfg_cnt_width(CFG_BEATS_K1, CFG_BEATS_K3);

    localparam bit               K1_SINGLE = (CFG_BEATS_K1 == 1);
    localparam bit               K3_SINGLE = (CFG_BEATS_K3 == 1);
    localparam logic [CNT_W-1:0] LOAD_K1   = CNT_W'(K1_SINGLE ? 0 : CFG_BEATS_K1 - 2);
    localparam logic [CNT_W-1:0] LOAD_K3   = CNT_W'(K3_SINGLE ? 0 : CFG_BEATS_K3 - 2);

    if (CFG_BEATS_K1 < 1 || CFG_BEATS_K3 < 1) begin : g_bad_beats
        $error("CFG_BEATS_K1 and CFG_BEATS_K3 must both be at least 1");
    end
    if (BITS_KERNEL_H < 1 || BITS_KERNEL_H > TUSER_WIDTH) begin : g_bad_kh
        $error("BITS_KERNEL_H must fit inside TUSER_WIDTH");
    end

    seq_state_e            state_q, state_d;
    logic [CNT_W-1:0]      cfg_cnt_q, cfg_cnt_d;
    logic [ITER_WIDTH-1:0] iter_q, iter_d;

    logic                     skid_ready;
    logic                     skid_in_valid;
    logic [SKID_W-1:0]        skid_in_data;
    logic [SKID_W-1:0]        skid_out_data;
    logic                     cfg_sel;
    logic                     cfg_hs;
    logic                     dat_hs;
    logic [BITS_KERNEL_H-1:0] kh_1;
    logic [MUSER_W-1:0]       cfg_user;
    logic [MUSER_W-1:0]       dat_user;

    // Only the stream owned by the current phase ever sees ready
    assign cfg_sel      = (state_q != ST_DATA);
    assign s_cfg_tready = skid_ready & cfg_sel;
    assign s_dat_tready = skid_ready & ~cfg_sel;
    assign cfg_hs       = s_cfg_tvalid & s_cfg_tready;
    assign dat_hs       = s_dat_tvalid & s_dat_tready;
    assign kh_1         = s_cfg_tuser[BITS_KERNEL_H-1:0];

    always_comb begin
        state_d   = state_q;
        cfg_cnt_d = cfg_cnt_q;
        iter_d    = iter_q;
        case (state_q)
            ST_CFG_FIRST: begin
                if (cfg_hs) begin
                    if (kh_1 == '0) begin
                        state_d   = K1_SINGLE ? ST_DATA : ST_CFG_REST;
                        cfg_cnt_d = K1_SINGLE ? cfg_cnt_q : LOAD_K1;
                    end else begin
                        state_d   = K3_SINGLE ? ST_DATA : ST_CFG_REST;
                        cfg_cnt_d = K3_SINGLE ? cfg_cnt_q : LOAD_K3;
                    end
                end
            end
            ST_CFG_REST: begin
                if (cfg_hs) begin
                    if (cfg_cnt_q == '0) begin
                        state_d = ST_DATA;
                    end else begin
                        cfg_cnt_d = cfg_cnt_q - 1'b1;
                    end
                end
            end
            ST_DATA: begin
                if (dat_hs && s_dat_tlast) begin
                    state_d = ST_CFG_FIRST;
                    iter_d  = iter_q + 1'b1;
                end
            end
            default: state_d = ST_CFG_FIRST;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q   <= ST_CFG_FIRST;
            cfg_cnt_q <= '0;
            iter_q    <= '0;
        end else begin
            state_q   <= state_d;
            cfg_cnt_q <= cfg_cnt_d;
            iter_q    <= iter_d;
        end
    end

    always_comb begin
        cfg_user                      = '0;
        cfg_user[TUSER_WIDTH-1:0]     = s_cfg_tuser;
        cfg_user[IS_CFG_BIT]          = 1'b1;
        dat_user                      = '0;
        dat_user[TUSER_WIDTH-1:0]     = s_dat_tuser;
    end

    // Skid word layout: {tlast, tuser_with_is_config, tdata}
    assign skid_in_valid = cfg_sel ? s_cfg_tvalid : s_dat_tvalid;
    assign skid_in_data  = cfg_sel ? {1'b0, cfg_user, s_cfg_tdata}
                                   : {s_dat_tlast, dat_user, s_dat_tdata};

    axis_skid_buffer #(
        .WIDTH(SKID_W)
    ) u_skid (
        .clk_i    (aclk),
        .rst_ni   (aresetn),
        .s_valid_i(skid_in_valid),
        .s_ready_o(skid_ready),
        .s_data_i (skid_in_data),
        .m_valid_o(m_axis_tvalid),
        .m_ready_i(m_axis_tready),
        .m_data_o (skid_out_data)
    );

    assign m_axis_tdata = skid_out_data[DATA_WIDTH-1:0];
    assign m_axis_tuser = skid_out_data[DATA_WIDTH +: MUSER_W];
    assign m_axis_tlast = skid_out_data[SKID_W-1];
    assign iter_count   = iter_q;
    assign debug_state  = state_q;

endmodule

// File: tb/tb_axis_lrelu_config_sequencer.sv
// Scoreboard bench for axis_lrelu_config_sequencer: directed bursts, early data,
// stalled 9th config beat, one-beat data phase, random backpressure, mid-burst reset.
module tb_axis_lrelu_config_sequencer;

    localparam int DW = 512;
    localparam int UW = 8;
    localparam int IW = 16;

    logic          aclk = 1'b0;
    logic          aresetn;
    logic          s_cfg_tvalid;
    logic          s_cfg_tready;
    logic [DW-1:0] s_cfg_tdata;
    logic [UW-1:0] s_cfg_tuser;
    logic          s_dat_tvalid;
    logic          s_dat_tready;
    logic [DW-1:0] s_dat_tdata;
    logic [UW-1:0] s_dat_tuser;
    logic          s_dat_tlast;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic [DW-1:0] m_axis_tdata;
    logic [UW:0]   m_axis_tuser;
    logic          m_axis_tlast;
    logic [IW-1:0] iter_count;
    logic [1:0]    debug_state;

    always #5 aclk = ~aclk;

    axis_lrelu_config_sequencer dut (
        .aclk         (aclk),
        .aresetn      (aresetn),
        .s_cfg_tvalid (s_cfg_tvalid),
        .s_cfg_tready (s_cfg_tready),
        .s_cfg_tdata  (s_cfg_tdata),
        .s_cfg_tuser  (s_cfg_tuser),
        .s_dat_tvalid (s_dat_tvalid),
        .s_dat_tready (s_dat_tready),
        .s_dat_tdata  (s_dat_tdata),
        .s_dat_tuser  (s_dat_tuser),
        .s_dat_tlast  (s_dat_tlast),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tuser (m_axis_tuser),
        .m_axis_tlast (m_axis_tlast),
        .iter_count   (iter_count),
        .debug_state  (debug_state)
    );

    typedef struct packed {
        logic [UW:0]   user;
        logic          last;
        logic [DW-1:0] data;
    } exp_t;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [UW-1:0] user;
        logic          last;
    } beat_t;

    exp_t  exp_q[$];
    beat_t cfg_q[$];
    beat_t dat_q[$];
    beat_t hold_q[$];

    int n_cmp = 0;
    int n_bad = 0;
    int seq = 0;
    int cyc = 0;
    int cfg_hs_total = 0;
    int out_total = 0;
    int hs_cyc[$];
    bit sb_en = 1'b1;
    bit abort = 1'b0;
    bit rand_rdy = 1'b0;
    int kh_tab[4] = '{0, 2, 1, 3};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Queue one iteration; expected output is pushed as the stimulus is issued
    task automatic add_iter(input int kh, input int ndata, input bit hold, input bit track);
        int         nb;
        beat_t      x;
        exp_t       e;
        logic [1:0] khb;
        logic [31:0] s32;
        nb  = (kh == 0) ? 4 : 8;
        khb = 2'(kh);
        for (int b = 0; b < nb; b++) begin
            seq++;
            s32    = 32'(seq);
            x.data = {16'hC0F1, {464{1'b0}}, s32};
            x.user = {s32[5:0], (b == 0) ? khb : ~khb};
            x.last = 1'b0;
            cfg_q.push_back(x);
            if (track) begin
                e.user = {1'b1, x.user};
                e.last = 1'b0;
                e.data = x.data;
                exp_q.push_back(e);
            end
        end
        for (int i = 0; i < ndata; i++) begin
            seq++;
            s32    = 32'(seq);
            x.data = {16'hDA7A, {464{1'b0}}, s32};
            x.user = s32[7:0] ^ 8'h5A;
            x.last = (i == ndata - 1);
            if (hold) hold_q.push_back(x);
            else dat_q.push_back(x);
            if (track) begin
                e.user = {1'b0, x.user};
                e.last = x.last;
                e.data = x.data;
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic wait_cfg(input int target);
        int n = 0;
        while (cfg_hs_total < target && n < 5000) begin
            @(negedge aclk); #1;
            n++;
        end
        chk("wait_cfg_handshakes", 64'(cfg_hs_total >= target), 64'd1);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() > 0 && n < 20000) begin
            @(negedge aclk); #1;
            n++;
        end
        chk("drain_scoreboard_left", 64'(exp_q.size()), 64'd0);
        repeat (2) @(negedge aclk);
        #1;
    endtask

    task automatic gap_chk(input string name, input int start, input int n);
        if (hs_cyc.size() >= start + n) begin
            chk(name, 64'(hs_cyc[start+n-1] - hs_cyc[start]), 64'(n - 1));
        end else begin
            chk({name, "_beats"}, 64'(hs_cyc.size() - start), 64'(n));
        end
    endtask

    task automatic reset_checks(input string p);
        chk({p, "_m_tvalid"}, 64'(m_axis_tvalid), 64'd0);
        chk({p, "_m_tdata"}, 64'(|m_axis_tdata), 64'd0);
        chk({p, "_m_tuser"}, 64'(m_axis_tuser), 64'd0);
        chk({p, "_m_tlast"}, 64'(m_axis_tlast), 64'd0);
        chk({p, "_cfg_tready"}, 64'(s_cfg_tready), 64'd0);
        chk({p, "_dat_tready"}, 64'(s_dat_tready), 64'd0);
        chk({p, "_iter_count"}, 64'(iter_count), 64'd0);
        chk({p, "_debug_state"}, 64'(debug_state), 64'd0);
    endtask

    always @(posedge aclk) cyc <= cyc + 1;

    initial begin
        m_axis_tready = 1'b1;
        forever begin
            @(posedge aclk); #1;
            m_axis_tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin : cfg_driver
        beat_t x;
        s_cfg_tvalid = 1'b0;
        s_cfg_tdata  = '0;
        s_cfg_tuser  = '0;
        #1;
        forever begin
            if (cfg_q.size() > 0) begin
                x = cfg_q.pop_front();
                s_cfg_tvalid = 1'b1;
                s_cfg_tdata  = x.data;
                s_cfg_tuser  = x.user;
                @(negedge aclk);
                while (!s_cfg_tready && !abort) @(negedge aclk);
                @(posedge aclk); #1;
            end else begin
                s_cfg_tvalid = 1'b0;
                @(posedge aclk); #1;
            end
        end
    end

    initial begin : dat_driver
        beat_t x;
        s_dat_tvalid = 1'b0;
        s_dat_tdata  = '0;
        s_dat_tuser  = '0;
        s_dat_tlast  = 1'b0;
        #1;
        forever begin
            if (dat_q.size() > 0) begin
                x = dat_q.pop_front();
                s_dat_tvalid = 1'b1;
                s_dat_tdata  = x.data;
                s_dat_tuser  = x.user;
                s_dat_tlast  = x.last;
                @(negedge aclk);
                while (!s_dat_tready && !abort) @(negedge aclk);
                @(posedge aclk); #1;
            end else begin
                s_dat_tvalid = 1'b0;
                s_dat_tlast  = 1'b0;
                @(posedge aclk); #1;
            end
        end
    end

    initial begin : monitor
        exp_t          e;
        bit            stalled;
        logic [DW-1:0] p_data;
        logic [UW:0]   p_user;
        logic          p_last;
        stalled = 1'b0;
        forever begin
            @(negedge aclk);
            if (!aresetn) begin
                stalled = 1'b0;
                continue;
            end
            if (s_cfg_tvalid && s_cfg_tready) cfg_hs_total++;
            if (stalled) begin
                n_cmp++;
                if (!m_axis_tvalid || m_axis_tdata !== p_data || m_axis_tuser !== p_user
                    || m_axis_tlast !== p_last) begin
                    n_bad++;
                    $display("FAIL stall_stable: got v=%b user=%h last=%b data=%h expected v=1 user=%h last=%b data=%h",
                             m_axis_tvalid, m_axis_tuser, m_axis_tlast, m_axis_tdata[31:0],
                             p_user, p_last, p_data[31:0]);
                end
            end
            if (m_axis_tvalid && m_axis_tready) begin
                hs_cyc.push_back(cyc);
                if (sb_en) begin
                    n_cmp++;
                    if (exp_q.size() == 0) begin
                        n_bad++;
                        $display("FAIL sb_unexpected: got user=%h data=%h expected no beat",
                                 m_axis_tuser, m_axis_tdata[31:0]);
                    end else begin
                        e = exp_q.pop_front();
                        if (m_axis_tuser !== e.user || m_axis_tlast !== e.last || m_axis_tdata !== e.data) begin
                            n_bad++;
                            $display("FAIL sb_beat%0d: got user=%h last=%b data=%h_%h expected user=%h last=%b data=%h_%h",
                                     out_total, m_axis_tuser, m_axis_tlast, m_axis_tdata[DW-1 -: 16],
                                     m_axis_tdata[31:0], e.user, e.last, e.data[DW-1 -: 16], e.data[31:0]);
                        end else begin
                            $display("beat %0d user=%h last=%b data=%h ok", out_total, m_axis_tuser,
                                     m_axis_tlast, m_axis_tdata[31:0]);
                        end
                    end
                end
                out_total++;
            end
            stalled = m_axis_tvalid && !m_axis_tready;
            p_data  = m_axis_tdata;
            p_user  = m_axis_tuser;
            p_last  = m_axis_tlast;
        end
    end

    initial begin : watchdog
        repeat (80000) @(posedge aclk);
        n_bad++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin : main
        int base;
        int st;
        aresetn = 1'b0;
        // kh_1=0 burst with data offered from reset
        add_iter(0, 10, 1'b0, 1'b1);
        repeat (3) @(posedge aclk);
        #1;
        reset_checks("por");
        aresetn = 1'b1;
        st = out_total;
        @(negedge aclk); #1;
        chk("cfg_tready_first_cycle", 64'(s_cfg_tready), 64'd0);
        @(negedge aclk); #1;
        chk("cfg_tready_second_cycle", 64'(s_cfg_tready), 64'd1);
        wait_cfg(2);
        chk("early_dat_tvalid", 64'(s_dat_tvalid), 64'd1);
        chk("early_dat_tready", 64'(s_dat_tready), 64'd0);
        drain();
        gap_chk("t1_no_gap", st, 14);
        chk("t1_iter_count", 64'(iter_count), 64'd1);

        // kh_1=2 burst, next burst offered back-to-back while data is withheld
        base = cfg_hs_total;
        add_iter(2, 3, 1'b1, 1'b1);
        add_iter(0, 2, 1'b1, 1'b1);
        wait_cfg(base + 8);
        repeat (6) @(negedge aclk);
        #1;
        chk("cfg9_not_consumed", 64'(cfg_hs_total - base), 64'd8);
        chk("cfg9_tvalid", 64'(s_cfg_tvalid), 64'd1);
        chk("cfg9_tready", 64'(s_cfg_tready), 64'd0);
        chk("cfg9_dat_tready", 64'(s_dat_tready), 64'd1);
        chk("cfg9_state", 64'(debug_state), 64'd2);
        while (hold_q.size() > 0) dat_q.push_back(hold_q.pop_front());
        drain();
        chk("t2_iter_count", 64'(iter_count), 64'd3);

        // one-beat data phase followed directly by the next burst
        st = out_total;
        add_iter(1, 1, 1'b0, 1'b1);
        add_iter(0, 2, 1'b0, 1'b1);
        drain();
        gap_chk("t3_no_gap", st, 15);
        chk("t3_iter_count", 64'(iter_count), 64'd5);

        // 100 mixed iterations under random backpressure
        rand_rdy = 1'b1;
        for (int i = 0; i < 100; i++) add_iter(kh_tab[i%4], (i % 5) + 1, 1'b0, 1'b1);
        drain();
        rand_rdy = 1'b0;
        chk("t4_iter_count", 64'(iter_count), 64'd105);

        // reset after 3 of 8 config beats
        sb_en = 1'b0;
        base  = cfg_hs_total;
        add_iter(1, 0, 1'b0, 1'b0);
        wait_cfg(base + 3);
        @(posedge aclk); #1;
        aresetn = 1'b0;
        abort   = 1'b1;
        cfg_q.delete();
        dat_q.delete();
        #1;
        reset_checks("midrst");
        repeat (3) @(posedge aclk);
        #1;
        abort   = 1'b0;
        sb_en   = 1'b1;
        aresetn = 1'b1;
        @(negedge aclk); #1;
        chk("rst_cfg_tready_first_cycle", 64'(s_cfg_tready), 64'd0);
        @(negedge aclk); #1;
        chk("rst_cfg_tready_second_cycle", 64'(s_cfg_tready), 64'd1);
        st = out_total;
        add_iter(3, 4, 1'b0, 1'b1);
        drain();
        gap_chk("t5_no_gap", st, 12);
        chk("t5_iter_count", 64'(iter_count), 64'd1);
        chk("t5_state", 64'(debug_state), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
